// File: rtl/switch_debouncer.sv
// Per-bit switch debouncer: 2-flop synchronizer + STABLE/COUNTING FSM per lane.
// Define SW_DEBOUNCE_EDGE_EN to build the registered rise_o/fall_o pulses.

module switch_debouncer_lane #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic raw_i,
  output logic sw_o,
  output logic rise_o,
  output logic fall_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  typedef enum logic {STABLE = 1'b0, COUNTING = 1'b1} state_e;

  logic          s1, s2;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sw_q;
  logic          accept;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw_i;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= STABLE;
      cnt_q   <= '0;
      sw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sw_q    <= sw_q ^ accept;
    end
  end

  // Any return to the accepted level drops the count; no partial credit.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    accept  = 1'b0;
    case (state_q)
      STABLE: begin
        if (s2 != sw_q) begin
          state_d = COUNTING;
          cnt_d   = CW'(1);
        end
      end
      COUNTING: begin
        if (s2 == sw_q) begin
          state_d = STABLE;
        end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
          state_d = STABLE;
          accept  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = STABLE;
    endcase
  end

`ifdef SW_DEBOUNCE_EDGE_EN
  logic rise_q, fall_q;

  // Pulses load on the same edge sw_q flips, so they line up with the new level.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= accept & ~sw_q;
      fall_q <= accept & sw_q;
    end
  end

  always_comb begin
    sw_o   = sw_q;
    rise_o = rise_q;
    fall_o = fall_q;
  end
`else
  always_comb begin
    sw_o   = sw_q;
    rise_o = 1'b0;
    fall_o = 1'b0;
  end
`endif

endmodule

module switch_debouncer #(
  parameter int N_BITS          = 4,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [N_BITS-1:0] sw_raw_i,
  output logic [N_BITS-1:0] sw_o,
  output logic [N_BITS-1:0] rise_o,
  output logic [N_BITS-1:0] fall_o
);
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_cfg
    $fatal(1, "switch_debouncer: DEBOUNCE_CYCLES must be >= 2");
  end

  for (genvar i = 0; i < N_BITS; i++) begin : g_lane
    switch_debouncer_lane #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_lane (
      .clk_i  (clk_i),
      .rst_n_i(rst_n_i),
      .raw_i  (sw_raw_i[i]),
      .sw_o   (sw_o[i]),
      .rise_o (rise_o[i]),
      .fall_o (fall_o[i])
    );
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed + random bench for switch_debouncer against a sliding-window reference model.
module tb_switch_debouncer;
  localparam int N = 4;
  localparam int D = 8;
`ifdef SW_DEBOUNCE_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic         clk_i    = 1'b0;
  logic         rst_n_i  = 1'b0;
  logic [N-1:0] sw_raw_i = '0;
  logic [N-1:0] sw_o, rise_o, fall_o;

  int checks = 0;
  int errors = 0;
  int rise2  = 0;
  int fall2  = 0;

  // Reference: sync = raw delayed two edges; a bit flips when the last D sync
  // samples since reset all disagree with its current debounced level.
  logic [N-1:0] m_sw, m_rise, m_fall;
  logic [N-1:0] rq[$];
  logic [N-1:0] sq[$];

  switch_debouncer #(.N_BITS(N), .DEBOUNCE_CYCLES(D)) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .sw_raw_i(sw_raw_i),
    .sw_o    (sw_o),
    .rise_o  (rise_o),
    .fall_o  (fall_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %b exp %b", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_sw = '0; m_rise = '0; m_fall = '0;
    rq.delete(); rq.push_back('0); rq.push_back('0);
    sq.delete();
  endfunction

  function automatic void model_step();
    logic [N-1:0] sync, nsw;
    bit flip;
    sync = rq.pop_front();
    rq.push_back(sw_raw_i);
    sq.push_back(sync);
    if (sq.size() > D) sq.delete(0);
    nsw = m_sw;
    if (sq.size() == D) begin
      for (int b = 0; b < N; b++) begin
        flip = 1'b1;
        foreach (sq[j]) if (sq[j][b] == m_sw[b]) flip = 1'b0;
        if (flip) nsw[b] = ~m_sw[b];
      end
    end
    m_rise = EDGE_EN ? (nsw & ~m_sw) : '0;
    m_fall = EDGE_EN ? (~nsw & m_sw) : '0;
    m_sw   = nsw;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    if (rst_n_i) model_step();
    #1;
    rise2 += int'(rise_o[2]);
    fall2 += int'(fall_o[2]);
    chk("sw_o", sw_o, m_sw);
    chk("rise_o", rise_o, m_rise);
    chk("fall_o", fall_o, m_fall);
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse_reset(input int n);
    rst_n_i = 1'b0;
    model_reset();
    #1;
    chk("rst_sw", sw_o, '0);
    chk("rst_rise", rise_o, '0);
    chk("rst_fall", fall_o, '0);
    ticks(n);
    @(negedge clk_i);
    rst_n_i = 1'b1;
  endtask

  // First tick is the s1 capture edge k; the rise must land on edge k+D+1.
  task automatic latency(input string tag, input int b, input int exp_e);
    int e = -1;
    do begin
      tick();
      e++;
    end while (sw_o[b] !== 1'b1 && e < 40);
    checks++;
    assert (e == exp_e) else begin
      errors++;
      $error("FAIL %s got %0d exp %0d", tag, e, exp_e);
    end
  endtask

  initial begin
    model_reset();
    pulse_reset(3);
    ticks(4);

    // Single-bit acceptance latency
    sw_raw_i = 4'b0001;
    latency("lat_b0", 0, D + 1);
    ticks(3);

    // Short glitch on bit 1 rejected
    sw_raw_i = 4'b0011;
    ticks(5);
    sw_raw_i = 4'b0001;
    ticks(15);
    chk("glitch_b1", sw_o, 4'b0001);

    // Bounce on bit 2, then settle high
    rise2 = 0; fall2 = 0;
    for (int i = 0; i < 30; i++) begin
      if (i % 3 == 0) sw_raw_i[2] = ~sw_raw_i[2];
      tick();
    end
    sw_raw_i[2] = 1'b1;
    latency("lat_b2", 2, D + 1);
    ticks(5);
    chk("bounce_rise_cnt", N'(rise2), EDGE_EN ? N'(1) : N'(0));
    chk("bounce_fall_cnt", N'(fall2), N'(0));

    // Simultaneous multi-bit change
    sw_raw_i = 4'b0000;
    ticks(12);
    sw_raw_i = 4'b1001;
    ticks(D + 1);
    chk("multi_pre", sw_o, 4'b0000);
    tick();
    chk("multi_sw", sw_o, 4'b1001);
    chk("multi_rise", rise_o, EDGE_EN ? 4'b1001 : 4'b0000);
    tick();
    chk("multi_rise_end", rise_o, 4'b0000);
    sw_raw_i = 4'b0000;
    ticks(D + 1);
    tick();
    chk("multi_fall", fall_o, EDGE_EN ? 4'b1001 : 4'b0000);
    chk("multi_sw_low", sw_o, 4'b0000);

    // Reset mid-count (counter at 4) discards progress
    sw_raw_i = 4'b1000;
    ticks(6);
    pulse_reset(2);
    latency("lat_rst", 3, D + 1);
    ticks(4);

    // Random bouncing on all bits
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 9) == 0) sw_raw_i[b] = ~sw_raw_i[b];
      if (i == 1500) pulse_reset($urandom_range(1, 4));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
